// File: rtl/colision_vehiculos_pkg.sv
// Shared game definitions for the frog-crossing blocks: bus widths and game state encodings.
// Imported by the collision block and by the vehicle-level block so both agree on the state values.
// Holds no logic, only constants.
package colision_vehiculos_pkg;

    localparam int DATAWIDTH_BUS    = 8;
    localparam int DATAWIDTH_NVL    = 2;
    localparam int DATAWIDTH_ESTADO = 3;

    // Game state encodings; the vehicle-level block decodes these same values.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_JUGANDO  = 3'd1;
    localparam logic [2:0] ST_CHOQUE   = 3'd2;
    localparam logic [2:0] ST_NIVEL_OK = 3'd3;
    localparam logic [2:0] ST_FIN      = 3'd4;
    localparam logic [2:0] ST_GANO     = 3'd5;

    // Frog row meanings: 0..5 are lanes, 6 is the start bank, 7 is the goal.
    localparam logic [2:0] FILA_ULTIMO_CARRIL = 3'd5;
    localparam logic [2:0] FILA_SALIDA        = 3'd6;
    localparam logic [2:0] FILA_META          = 3'd7;

endpackage

// File: rtl/colision_vehiculos_hold_timer.sv
// hold_timer: counts the cycles spent in a timed game state and flags the last one.
// Ports: clk_i/rst_i (async active-high), clr_i restarts the count, en_i advances it,
//        done_o is high during the final cycle of a HOLD_CYCLES-long hold (combinational).
module hold_timer #(
    parameter int HOLD_CYCLES = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    logic [3:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= 4'd0;
        end else if (clr_i) begin
            cnt_q <= 4'd0;
        end else if (en_i) begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    // The count starts at 0 on the entry edge, so the hold covers counts 0..HOLD_CYCLES-1.
    assign done_o = en_i && (cnt_q == 4'(HOLD_CYCLES - 1));

endmodule

// File: rtl/colision_vehiculos.sv
// colision_vehiculos: game-flow controller detecting frog/vehicle collisions, tracking lives and level.
// Ports: CV_CLOCK, CV_RESET (async active-high), six lane occupancy registers, frog row/column,
//        CV_START_IN; outputs registered state, level, lives, and one-cycle COLISION / RANA_RESET pulses.
module colision_vehiculos #(
    parameter int DATAWIDTH_BUS    = colision_vehiculos_pkg::DATAWIDTH_BUS,
    parameter int DATAWIDTH_NVL    = colision_vehiculos_pkg::DATAWIDTH_NVL,
    parameter int DATAWIDTH_ESTADO = colision_vehiculos_pkg::DATAWIDTH_ESTADO,
    parameter int VIDAS_INIT       = 3,
    parameter int HOLD_CYCLES      = 8
) (
    input  logic                        CV_CLOCK,
    input  logic                        CV_RESET,
    input  logic [DATAWIDTH_BUS-1:0]    CV_REG_0_IN,
    input  logic [DATAWIDTH_BUS-1:0]    CV_REG_1_IN,
    input  logic [DATAWIDTH_BUS-1:0]    CV_REG_2_IN,
    input  logic [DATAWIDTH_BUS-1:0]    CV_REG_3_IN,
    input  logic [DATAWIDTH_BUS-1:0]    CV_REG_4_IN,
    input  logic [DATAWIDTH_BUS-1:0]    CV_REG_5_IN,
    input  logic [2:0]                  CV_RANA_FILA_IN,
    input  logic [2:0]                  CV_RANA_COL_IN,
    input  logic                        CV_START_IN,
    output logic [DATAWIDTH_ESTADO-1:0] CV_ESTADO_OUT,
    output logic [DATAWIDTH_NVL-1:0]    CV_NV_OUT,
    output logic [1:0]                  CV_VIDAS_OUT,
    output logic                        CV_COLISION_OUT,
    output logic                        CV_RANA_RESET_OUT
);

    import colision_vehiculos_pkg::*;

    localparam logic [1:0]               VIDAS_RST = 2'(VIDAS_INIT);
    localparam logic [DATAWIDTH_NVL-1:0] NV_MAX    = '1;

    logic [DATAWIDTH_ESTADO-1:0] state_q, state_d;
    logic [DATAWIDTH_NVL-1:0]    nv_q, nv_d;
    logic [1:0]                  vidas_q, vidas_d;
    logic                        colision_q, colision_d;
    logic                        rana_reset_q, rana_reset_d;

    logic [DATAWIDTH_BUS-1:0]    lane;
    logic                        hit;
    logic                        hold_clr;
    logic                        hold_en;
    logic                        hold_done;

    // Lane selected by the frog row; rows 6/7 are off the road and select nothing.
    always_comb begin
        lane = '0;
        case (CV_RANA_FILA_IN)
            3'd0:    lane = CV_REG_0_IN;
            3'd1:    lane = CV_REG_1_IN;
            3'd2:    lane = CV_REG_2_IN;
            3'd3:    lane = CV_REG_3_IN;
            3'd4:    lane = CV_REG_4_IN;
            3'd5:    lane = CV_REG_5_IN;
            default: lane = '0;
        endcase
    end

    assign hit = (state_q == ST_JUGANDO) && (CV_RANA_FILA_IN <= FILA_ULTIMO_CARRIL)
                 && lane[CV_RANA_COL_IN];

    always_comb begin
        state_d      = state_q;
        nv_d         = nv_q;
        vidas_d      = vidas_q;
        colision_d   = 1'b0;
        rana_reset_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (CV_START_IN) begin
                    state_d      = ST_JUGANDO;
                    vidas_d      = VIDAS_RST;
                    nv_d         = '0;
                    rana_reset_d = 1'b1;
                end
            end
            ST_JUGANDO: begin
                if (hit) begin
                    state_d    = ST_CHOQUE;
                    vidas_d    = (vidas_q == 2'd0) ? 2'd0 : vidas_q - 2'd1;
                    colision_d = 1'b1;
                end else if (CV_RANA_FILA_IN == FILA_META) begin
                    if (nv_q == NV_MAX) begin
                        state_d = ST_GANO;
                    end else begin
                        state_d = ST_NIVEL_OK;
                        nv_d    = nv_q + 1'b1;
                    end
                end
            end
            ST_CHOQUE: begin
                if (hold_done) begin
                    if (vidas_q == 2'd0) begin
                        state_d = ST_FIN;
                    end else begin
                        state_d      = ST_JUGANDO;
                        rana_reset_d = 1'b1;
                    end
                end
            end
            ST_NIVEL_OK: begin
                if (hold_done) begin
                    state_d      = ST_JUGANDO;
                    rana_reset_d = 1'b1;
                end
            end
            ST_FIN, ST_GANO: begin
                if (CV_START_IN) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Any state change restarts the timer, so every hold starts from zero.
    assign hold_clr = (state_d != state_q);
    assign hold_en  = (state_q == ST_CHOQUE) || (state_q == ST_NIVEL_OK);

    hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk_i  (CV_CLOCK),
        .rst_i  (CV_RESET),
        .clr_i  (hold_clr),
        .en_i   (hold_en),
        .done_o (hold_done)
    );

    always_ff @(posedge CV_CLOCK or posedge CV_RESET) begin
        if (CV_RESET) begin
            state_q      <= ST_IDLE;
            nv_q         <= '0;
            vidas_q      <= VIDAS_RST;
            colision_q   <= 1'b0;
            rana_reset_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            nv_q         <= nv_d;
            vidas_q      <= vidas_d;
            colision_q   <= colision_d;
            rana_reset_q <= rana_reset_d;
        end
    end

    assign CV_ESTADO_OUT     = state_q;
    assign CV_NV_OUT         = nv_q;
    assign CV_VIDAS_OUT      = vidas_q;
    assign CV_COLISION_OUT   = colision_q;
    assign CV_RANA_RESET_OUT = rana_reset_q;

endmodule

// File: tb/tb_colision_vehiculos.sv
// Directed bench for colision_vehiculos: start, collisions, lives exhaustion, level-ups, win, reset abort.
module tb_colision_vehiculos;

    logic       clk;
    logic       rst;
    logic [7:0] reg0, reg1, reg2, reg3, reg4, reg5;
    logic [2:0] fila;
    logic [2:0] col;
    logic       start;
    logic [2:0] estado;
    logic [1:0] nv;
    logic [1:0] vidas;
    logic       colision;
    logic       rana_reset;

    int n_checks = 0;
    int n_errors = 0;

    colision_vehiculos dut (
        .CV_CLOCK          (clk),
        .CV_RESET          (rst),
        .CV_REG_0_IN       (reg0),
        .CV_REG_1_IN       (reg1),
        .CV_REG_2_IN       (reg2),
        .CV_REG_3_IN       (reg3),
        .CV_REG_4_IN       (reg4),
        .CV_REG_5_IN       (reg5),
        .CV_RANA_FILA_IN   (fila),
        .CV_RANA_COL_IN    (col),
        .CV_START_IN       (start),
        .CV_ESTADO_OUT     (estado),
        .CV_NV_OUT         (nv),
        .CV_VIDAS_OUT      (vidas),
        .CV_COLISION_OUT   (colision),
        .CV_RANA_RESET_OUT (rana_reset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clock edges, leaving time 1 unit past the last edge for sampling/driving.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        fila  = 3'd6;
        col   = 3'd0;
        reg0  = 8'h00; reg1 = 8'h00; reg2 = 8'h00;
        reg3  = 8'h00; reg4 = 8'h00; reg5 = 8'h00;
        #12;
        check("rst_estado", estado, 0);
        check("rst_nv", nv, 0);
        check("rst_vidas", vidas, 3);
        check("rst_colision", colision, 0);
        check("rst_rana", rana_reset, 0);

        // Game start
        @(posedge clk); #1;
        rst   = 1'b0;
        start = 1'b1;
        tick(1);
        check("start_estado", estado, 1);
        check("start_vidas", vidas, 3);
        check("start_nv", nv, 0);
        check("start_rana", rana_reset, 1);
        start = 1'b0;
        tick(1);
        check("start_rana_off", rana_reset, 0);
        check("play_estado", estado, 1);

        // Hit 1: lane 2, column 5; START held during the hold must be ignored
        fila = 3'd2; col = 3'd5; reg2 = 8'b0010_0000;
        tick(1);
        check("hit1_estado", estado, 2);
        check("hit1_colision", colision, 1);
        check("hit1_vidas", vidas, 2);
        fila = 3'd6; start = 1'b1;
        tick(1);
        check("hit1_col_once", colision, 0);
        check("hit1_hold_estado", estado, 2);
        tick(6);
        check("hit1_hold_end", estado, 2);
        check("hit1_hold_rana", rana_reset, 0);
        tick(1);
        check("hit1_back_estado", estado, 1);
        check("hit1_back_rana", rana_reset, 1);
        start = 1'b0;
        tick(1);
        check("hit1_rana_off", rana_reset, 0);

        // Hit 2: lane 0, column 0
        fila = 3'd0; col = 3'd0; reg0 = 8'h01;
        tick(1);
        check("hit2_estado", estado, 2);
        check("hit2_vidas", vidas, 1);
        fila = 3'd6;
        tick(8);
        check("hit2_back_estado", estado, 1);

        // Hit 3: lane 5, column 7 -> lives exhausted, FIN after hold
        fila = 3'd5; col = 3'd7; reg5 = 8'h80;
        tick(1);
        check("hit3_estado", estado, 2);
        check("hit3_vidas", vidas, 0);
        fila = 3'd6; start = 1'b1;
        tick(7);
        check("hit3_start_ignored", estado, 2);
        start = 1'b0;
        tick(1);
        check("fin_estado", estado, 4);
        check("fin_no_rana", rana_reset, 0);
        tick(3);
        check("fin_hold_estado", estado, 4);
        check("fin_hold_vidas", vidas, 0);
        start = 1'b1;
        tick(1);
        check("fin_to_idle", estado, 0);
        tick(1);
        check("restart_estado", estado, 1);
        check("restart_vidas", vidas, 3);
        check("restart_rana", rana_reset, 1);
        start = 1'b0;

        // Three level-ups through NIVEL_OK
        for (int l = 0; l < 3; l++) begin
            fila = 3'd7;
            tick(1);
            check("lvl_estado", estado, 3);
            check("lvl_nv", nv, l + 1);
            fila = 3'd6;
            tick(7);
            check("lvl_hold", estado, 3);
            tick(1);
            check("lvl_back", estado, 1);
            check("lvl_rana", rana_reset, 1);
        end

        // Goal at level 3 -> GANO
        fila = 3'd7;
        tick(1);
        check("gano_estado", estado, 5);
        check("gano_nv", nv, 3);
        fila = 3'd6;
        tick(2);
        check("gano_hold_estado", estado, 5);
        check("gano_hold_nv", nv, 3);
        start = 1'b1;
        tick(1);
        check("gano_to_idle", estado, 0);
        tick(1);
        check("new_game_estado", estado, 1);
        check("new_game_nv", nv, 0);
        start = 1'b0;

        // Start bank with every lane full: no collision
        reg0 = 8'hFF; reg1 = 8'hFF; reg2 = 8'hFF;
        reg3 = 8'hFF; reg4 = 8'hFF; reg5 = 8'hFF;
        fila = 3'd6; col = 3'd3;
        tick(3);
        check("bank_estado", estado, 1);
        check("bank_colision", colision, 0);
        check("bank_vidas", vidas, 3);

        // Reset in the middle of NIVEL_OK
        fila = 3'd7;
        tick(1);
        check("nivel_estado", estado, 3);
        check("nivel_nv", nv, 1);
        fila = 3'd6;
        tick(3);
        rst = 1'b1;
        #1;
        check("abort_estado", estado, 0);
        check("abort_nv", nv, 0);
        check("abort_vidas", vidas, 3);
        check("abort_colision", colision, 0);
        check("abort_rana", rana_reset, 0);
        tick(2);
        rst = 1'b0;
        tick(1);
        check("post_abort_estado", estado, 0);
        check("post_abort_rana", rana_reset, 0);
        check("post_abort_nv", nv, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/colision_vehiculos.md
COLISION_VEHICULOS -- requirements
Module: colision_vehiculos

Interface
REQ-001 Parameter DATAWIDTH_BUS, default 8, is the lane register width.
REQ-002 Parameter DATAWIDTH_NVL, default 2, is the level width.
REQ-003 Parameter DATAWIDTH_ESTADO, default 3, is the game state width.
REQ-004 Parameter VIDAS_INIT, default 3, is the lives loaded at game start.
REQ-005 Parameter HOLD_CYCLES, default 8, is the clock-cycle length of the CHOQUE and NIVEL_OK states.
REQ-006 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-007 CV_CLOCK  in  1  system clock; all state changes occur on its rising edge.
REQ-008 CV_RESET  in  1  asynchronous, active-high reset.
REQ-009 CV_REG_0_IN .. CV_REG_5_IN  in  8 each  lane occupancy; bit c=1 means a vehicle is in column c of that lane.
REQ-010 CV_RANA_FILA_IN  in  3  frog row: 0..5 are lanes, 6 is start, 7 is goal.
REQ-011 CV_RANA_COL_IN  in  3  frog column 0..7.
REQ-012 CV_START_IN  in  1  start/restart request, level-sampled.
REQ-013 CV_ESTADO_OUT  out  3  game state, fed to the vehicle-level block's state input.
REQ-014 CV_NV_OUT  out  2  current level 0..3, fed to the vehicle-level block's level input.
REQ-015 CV_VIDAS_OUT  out  2  remaining lives.
REQ-016 CV_COLISION_OUT  out  1  one-cycle pulse per detected collision.
REQ-017 CV_RANA_RESET_OUT  out  1  one-cycle pulse commanding the frog back to row 6.

Function
REQ-018 The state encodings SHALL be IDLE=0, JUGANDO=1, CHOQUE=2, NIVEL_OK=3, FIN=4, GANO=5, and CV_ESTADO_OUT SHALL equal the registered state.
- Encodings 6 and 7 SHALL recover to IDLE on the next edge.
REQ-019 The hit condition SHALL be: state is JUGANDO, FILA<=5, and bit COL of lane register FILA is 1, evaluated on the current inputs at the clock edge.
REQ-020 IDLE SHALL go to JUGANDO when START=1.
- On that edge: VIDAS<=VIDAS_INIT, NV<=0, and RANA_RESET pulses.
REQ-021 JUGANDO on a hit SHALL go to CHOQUE on the same edge.
- On that edge: VIDAS decrements by 1, and COLISION is 1 for exactly the first CHOQUE cycle.
REQ-022 JUGANDO with FILA=7 SHALL go to NIVEL_OK if NV<3, or to GANO if NV=3.
- FILA=7 and a hit are mutually exclusive by row.
REQ-023 CHOQUE SHALL last HOLD_CYCLES cycles.
- It then goes to FIN if VIDAS=0, otherwise to JUGANDO with a RANA_RESET pulse.
REQ-024 NIVEL_OK SHALL increment NV on its entry edge and last HOLD_CYCLES cycles.
- It then goes to JUGANDO with a RANA_RESET pulse.
REQ-025 FIN and GANO SHALL hold all outputs until START=1, then go to IDLE.
- START must be seen again in IDLE to begin a game.
REQ-026 CV_START_IN SHALL be ignored in JUGANDO, CHOQUE and NIVEL_OK.
REQ-027 VIDAS SHALL never wrap below 0, and NV SHALL never wrap above 3.
REQ-028 The hold counter SHALL clear on every state entry.
- It is 4 bits wide; HOLD_CYCLES ranges 1..15.
REQ-029 Each pulse output SHALL be registered and high for exactly one cycle per event.

Reset
REQ-030 While CV_RESET=1, the state SHALL be IDLE regardless of the clock.
REQ-031 While CV_RESET=1, the output values SHALL be: NV=0, VIDAS=VIDAS_INIT, COLISION=0, RANA_RESET=0, hold counter=0.
REQ-032 Reset asserted mid-CHOQUE or mid-NIVEL_OK SHALL abort the hold immediately, with no pulse emitted.

Structure
REQ-033 The shared game package SHALL hold the state encodings, DATAWIDTH_BUS, DATAWIDTH_NVL and DATAWIDTH_ESTADO, common with the vehicle-level block.
REQ-034 The hold timer SHALL be a sub-module, hold_timer, with clear, count enable and a done output.
REQ-035 The 6:1 lane mux and the bit select SHALL be combinational inside colision_vehiculos.

Verification
REQ-036 Reset, then START=1 for one cycle -> ESTADO=1, VIDAS=3, NV=0, and one RANA_RESET pulse.
REQ-037 JUGANDO, FILA=2, COL=5, REG_2=8'b00100000 -> next cycle ESTADO=2, COLISION=1 once, VIDAS=2; after 8 cycles ESTADO=1 with a RANA_RESET pulse.
REQ-038 Three hits with VIDAS_INIT=3 -> VIDAS=0, ESTADO=4 after the third hold, and START ignored during the hold.
REQ-039 FILA=7 at NV=0,1,2,3 in turn -> NIVEL_OK with NV=1,2,3 for the first three, then GANO (5) with NV=3.
REQ-040 FILA=6, all lanes 8'hFF -> no collision; then CV_RESET pulse mid-NIVEL_OK -> immediate IDLE, NV=0, no pulses.
